// File: rtl/mux_nto1_pipe.sv
// N-input WIDTH-bit multiplexer with a single registered output stage,
// valid/ready on both sides, and explicit-select or round-robin arbitration.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [NUM_IN-1:0]       in_valid_i,
  output logic [NUM_IN-1:0]       in_ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    rr_mode_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_sel_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q,  out_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  last_q,     last_d;

  logic              load_en;
  logic              gnt_any;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  scan_idx;
  logic [NUM_IN-1:0] grant;
  logic [WIDTH-1:0]  gnt_data;

  assign load_en = !out_valid_q || out_ready_i;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (!rr_mode_i) begin
      // An out-of-range select matches no channel, so it yields no grant.
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel_i == SEL_W'(i) && in_valid_i[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        scan_idx = SEL_W'((int'(last_q) + k) % NUM_IN);
        if (!gnt_any && in_valid_i[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_any && gnt_idx == SEL_W'(i)) begin
        grant[i] = 1'b1;
        gnt_data = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready_o = (reset_i || !load_en) ? '0 : grant;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load_en) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = gnt_data;
        out_sel_d  = gnt_idx;
        if (rr_mode_i) last_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_sel_o   = out_sel_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 4-input instance for the main flow and
// a 3-input instance for the out-of-range select case.
module tb_mux_nto1_pipe;

  logic         clk_i = 1'b0;
  logic         reset_i;

  logic [127:0] a_data;
  logic [3:0]   a_valid;
  logic [3:0]   a_ready;
  logic [1:0]   a_sel;
  logic         a_rr;
  logic [31:0]  a_odata;
  logic [1:0]   a_osel;
  logic         a_ovalid;
  logic         a_oready;

  logic [95:0]  b_data;
  logic [2:0]   b_valid;
  logic [2:0]   b_ready;
  logic [1:0]   b_sel;
  logic         b_rr;
  logic [31:0]  b_odata;
  logic [1:0]   b_osel;
  logic         b_ovalid;
  logic         b_oready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_data_i(a_data), .in_valid_i(a_valid), .in_ready_o(a_ready),
    .sel_i(a_sel), .rr_mode_i(a_rr),
    .out_data_o(a_odata), .out_sel_o(a_osel), .out_valid_o(a_ovalid),
    .out_ready_i(a_oready)
  );

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut_b (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_data_i(b_data), .in_valid_i(b_valid), .in_ready_o(b_ready),
    .sel_i(b_sel), .rr_mode_i(b_rr),
    .out_data_o(b_odata), .out_sel_o(b_osel), .out_valid_o(b_ovalid),
    .out_ready_i(b_oready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] d, input logic [1:0] s, input logic v);
    chk({tag, ".data"},  64'(a_odata),  64'(d));
    chk({tag, ".sel"},   64'(a_osel),   64'(s));
    chk({tag, ".valid"}, 64'(a_ovalid), 64'(v));
  endtask

  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;

  initial begin
    int rr_all [8];
    int rr_odd [4];
    rr_all = '{0, 1, 2, 3, 0, 1, 2, 3};
    rr_odd = '{1, 3, 1, 3};

    reset_i  = 1'b1;
    a_data   = {D3, D2, D1, D0};
    a_valid  = 4'hF;
    a_sel    = 2'd0;
    a_rr     = 1'b0;
    a_oready = 1'b1;
    b_data   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    b_valid  = 3'b000;
    b_sel    = 2'd0;
    b_rr     = 1'b0;
    b_oready = 1'b1;

    // T1: reset held two cycles with every channel valid
    tick();
    chk("t1.in_ready.c1", 64'(a_ready), 64'h0);
    tick();
    chk("t1.in_ready.c2", 64'(a_ready), 64'h0);
    chk_a("t1.out", 32'h0, 2'd0, 1'b0);
    a_valid = 4'h0;
    reset_i = 1'b0;

    // T2: explicit select of channel 2
    tick();
    a_sel   = 2'd2;
    a_valid = 4'b0100;
    #1;
    chk("t2.in_ready", 64'(a_ready), 64'h4);
    tick();
    chk_a("t2.out", D2, 2'd2, 1'b1);

    // T3: three stalled cycles with select and data moving underneath
    a_oready = 1'b0;
    a_valid  = 4'hF;
    for (int c = 0; c < 3; c++) begin
      a_sel = 2'(c * 2 + 1);
      a_data[64 +: 32] = 32'h5A5A_0000 + 32'(c);
      #1;
      chk("t3.in_ready", 64'(a_ready), 64'h0);
      tick();
      chk_a("t3.hold", D2, 2'd2, 1'b1);
    end
    a_data[64 +: 32] = D2;
    a_oready = 1'b1;
    a_sel    = 2'd1;
    #1;
    chk("t3.release.in_ready", 64'(a_ready), 64'h2);
    tick();
    chk_a("t3.release", D1, 2'd1, 1'b1);
    a_valid = 4'h0;
    tick();
    chk_a("t3.drain", D1, 2'd1, 1'b0);

    // T4: round-robin, pointer still at 3 so channel 0 wins first
    a_rr    = 1'b1;
    a_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t4.all.in_ready", 64'(a_ready), 64'(1 << rr_all[c]));
      tick();
      chk("t4.all.sel", 64'(a_osel), 64'(rr_all[c]));
    end
    a_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t4.odd.in_ready", 64'(a_ready), 64'(1 << rr_odd[c]));
      tick();
      chk("t4.odd.sel", 64'(a_osel), 64'(rr_odd[c]));
    end

    // T5: empty round-robin must leave the pointer where the last grant put it
    a_valid = 4'b0100;
    tick();
    chk_a("t5.ch2", D2, 2'd2, 1'b1);
    a_valid = 4'h0;
    #1;
    chk("t5.empty.in_ready", 64'(a_ready), 64'h0);
    tick();
    chk("t5.empty.valid", 64'(a_ovalid), 64'h0);
    tick();
    chk("t5.empty.valid2", 64'(a_ovalid), 64'h0);
    a_valid = 4'hF;
    #1;
    chk("t5.ptr.in_ready", 64'(a_ready), 64'h8);
    tick();
    chk_a("t5.ptr", D3, 2'd3, 1'b1);

    // T6: reset while stalled with pointer at 0; afterwards channel 0 wins again
    tick();
    chk("t6.pre.sel", 64'(a_osel), 64'h0);
    a_oready = 1'b0;
    tick();
    chk_a("t6.stall", D0, 2'd0, 1'b1);
    reset_i = 1'b1;
    #1;
    chk("t6.rst.in_ready", 64'(a_ready), 64'h0);
    tick();
    chk_a("t6.rst", 32'h0, 2'd0, 1'b0);
    reset_i  = 1'b0;
    a_oready = 1'b1;
    #1;
    chk("t6.post.in_ready", 64'(a_ready), 64'h1);
    tick();
    chk_a("t6.post", D0, 2'd0, 1'b1);

    // T5a: three-input instance, select 3 is out of range
    b_valid = 3'b111;
    b_sel   = 2'd1;
    #1;
    chk("t5b.sel1.in_ready", 64'(b_ready), 64'h2);
    tick();
    chk("t5b.sel1.data",  64'(b_odata),  64'hBBBB_0001);
    chk("t5b.sel1.valid", 64'(b_ovalid), 64'h1);
    b_sel = 2'd3;
    #1;
    chk("t5b.sel3.in_ready", 64'(b_ready), 64'h0);
    tick();
    chk("t5b.sel3.valid", 64'(b_ovalid), 64'h0);
    chk("t5b.sel3.data",  64'(b_odata),  64'hBBBB_0001);
    chk("t5b.sel3.sel",   64'(b_osel),   64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
